aes_inv_cipher_ctrl: RTL and testbench

//  Iterative AES-128 decryption controller. Captures one ciphertext block and sequences it through
//  the inverse round primitives (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) over one

---
 rtl/aes_inv_cipher_ctrl.sv | 169 ++++++++++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher controller. One shared 128-bit state register is walked through
// InvShiftRows, InvSubBytes, AddRoundKey and a time-shared InvMixColumns unit by a small FSM.
module aes_inv_cipher_ctrl #(
  parameter int NUM_ROUNDS         = 10,
  parameter int IMC_COLS_PER_CYCLE = 1
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          start,
  input  logic [0:127]                  ciphertext,
  input  logic [0:128*(NUM_ROUNDS+1)-1] key_schedule,
  output logic                          busy,
  output logic                          done,
  output logic [0:127]                  plaintext,
  output logic [3:0]                    round_idx
);

  if (!(IMC_COLS_PER_CYCLE == 1 || IMC_COLS_PER_CYCLE == 2 || IMC_COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("aes_inv_cipher_ctrl: IMC_COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISR, S_ISB, S_ARK, S_IMC, S_DONE} fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  fsm_t         r_fsm, w_fsm_nxt;
  logic [0:127] r_state, w_state_nxt;
  logic [0:127] r_pt, w_pt_nxt;
  logic [0:127] w_rk;
  logic [3:0]   r_round, w_round_nxt;
  logic [1:0]   r_col, w_col_nxt;
  logic [2:0]   w_col_sum;
  logic         r_busy, w_busy_nxt;
  logic         r_done, w_done_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Inverse affine map, then multiplicative inverse as b^254 (0 maps to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b, sq, r;
    b  = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    sq = b;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
    logic [0:127] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r+4)%4)+r) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
    logic [0:127] o;
    for (int b = 0; b < 16; b++) o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {gf_mul(a0,8'h0e) ^ gf_mul(a1,8'h0b) ^ gf_mul(a2,8'h0d) ^ gf_mul(a3,8'h09),
            gf_mul(a0,8'h09) ^ gf_mul(a1,8'h0e) ^ gf_mul(a2,8'h0b) ^ gf_mul(a3,8'h0d),
            gf_mul(a0,8'h0d) ^ gf_mul(a1,8'h09) ^ gf_mul(a2,8'h0e) ^ gf_mul(a3,8'h0b),
            gf_mul(a0,8'h0b) ^ gf_mul(a1,8'h0d) ^ gf_mul(a2,8'h09) ^ gf_mul(a3,8'h0e)};
  endfunction

  assign w_rk      = key_schedule[128*r_round +: 128];
  // Bit 2 of the sum marks the final column group of the current round.
  assign w_col_sum = {1'b0, r_col} + 3'(IMC_COLS_PER_CYCLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_pt_nxt    = r_pt;
    w_round_nxt = r_round;
    w_col_nxt   = r_col;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    case (r_fsm)
      S_IDLE: if (start) begin
        w_state_nxt = ciphertext ^ key_schedule[128*NUM_ROUNDS +: 128];
        w_round_nxt = LAST_RND;
        w_busy_nxt  = 1'b1;
        w_fsm_nxt   = S_ISR;
      end
      S_ISR: begin
        w_state_nxt = inv_shift_rows(r_state);
        w_fsm_nxt   = S_ISB;
      end
      S_ISB: begin
        w_state_nxt = inv_sub_bytes(r_state);
        w_fsm_nxt   = S_ARK;
      end
      S_ARK: begin
        w_state_nxt = r_state ^ w_rk;
        if (r_round != 4'd0) begin
          w_col_nxt = 2'd0;
          w_fsm_nxt = S_IMC;
        end else begin
          w_pt_nxt   = r_state ^ w_rk;
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
          w_fsm_nxt  = S_DONE;
        end
      end
      S_IMC: begin
        for (int k = 0; k < IMC_COLS_PER_CYCLE; k++)
          w_state_nxt[32*((int'(r_col)+k) & 3) +: 32] = inv_mix_col(r_state[32*((int'(r_col)+k) & 3) +: 32]);
        if (w_col_sum[2]) begin
          w_round_nxt = r_round - 4'd1;
          w_col_nxt   = 2'd0;
          w_fsm_nxt   = S_ISR;
        end else begin
          w_col_nxt = w_col_sum[1:0];
        end
      end
      S_DONE: if (!start) begin
        w_done_nxt = 1'b0;
        w_fsm_nxt  = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= '0;
      r_pt    <= '0;
      r_round <= 4'd0;
      r_col   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pt    <= w_pt_nxt;
      r_round <= w_round_nxt;
      r_col   <= w_col_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign plaintext = r_pt;
  assign round_idx = r_round;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward-AES reference model feeds a plaintext scoreboard; three
// instances cover the 1/2/4 column InvMixColumns schedules.
module tb_aes_inv_cipher_ctrl;

  localparam logic [0:127] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT1 = 128'h00112233445566778899aabbccddeeff;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [0:127]  ciphertext;
  logic [0:1407] ks;
  logic          busy, done, busy2, done2, busy4, done4;
  logic [0:127]  plaintext, pt2_o, pt4_o;
  logic [3:0]    round_idx, ri2, ri4;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            lat1, lat2, lat4;
  logic [7:0]    sb [256];
  logic [0:127]  q_pt [$];
  logic [3:0]    q_ri [$];

  always #5 Clk = ~Clk;

  aes_inv_cipher_ctrl dut (
    .Clk(Clk), .Reset(Reset), .start(start), .ciphertext(ciphertext), .key_schedule(ks),
    .busy(busy), .done(done), .plaintext(plaintext), .round_idx(round_idx));

  aes_inv_cipher_ctrl #(.IMC_COLS_PER_CYCLE(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start), .ciphertext(ciphertext), .key_schedule(ks),
    .busy(busy2), .done(done2), .plaintext(pt2_o), .round_idx(ri2));

  aes_inv_cipher_ctrl #(.IMC_COLS_PER_CYCLE(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .start(start), .ciphertext(ciphertext), .key_schedule(ks),
    .busy(busy4), .done(done4), .plaintext(pt4_o), .round_idx(ri4));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [0:1407] expand(input logic [0:127] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1407] k;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) k[32*i +: 32] = w[i];
    return k;
  endfunction

  function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:1407] k);
    logic [0:127] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ k[0 +: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[8*b +: 8] = sb[s[8*b +: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[8*(4*c+rr) +: 8] = s[8*(4*((c+rr)%4)+rr) +: 8];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[32*c +: 32];
          s[32*c +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = s ^ k[128*r +: 128];
    end
    return s;
  endfunction

  // mode 0: start pulse; 1: start held; 2: async reset at cycle 30; 3: start/ciphertext disturbed while busy
  task automatic run_op(input logic [0:127] ct, input logic [0:127] pt_exp, input int mode);
    logic [3:0] prev_ri;
    bit         ovl;
    ciphertext = ct;
    start      = 1'b1;
    q_pt.push_back(pt_exp);
    for (int r = 9; r >= 0; r--) q_ri.push_back(4'(r));
    lat1 = -1; lat2 = -1; lat4 = -1;
    ovl = 1'b0;
    prev_ri = 4'hf;
    @(negedge Clk);
    if (mode != 1) start = 1'b0;
    for (int cnt = 0; cnt < 200; cnt++) begin
      if (cnt > 0) @(negedge Clk);
      if (mode == 2 && cnt == 30) begin
        #2 Reset = 1'b1;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_plaintext", plaintext, 128'(0));
        check("midrst_round_idx", 128'(round_idx), 128'(0));
        q_pt.delete();
        q_ri.delete();
        return;
      end
      if ((busy && done) || (busy2 && done2) || (busy4 && done4)) ovl = 1'b1;
      if (busy && round_idx !== prev_ri) begin
        if (q_ri.size() != 0) check("round_idx_seq", 128'(round_idx), 128'(q_ri.pop_front()));
        else                  check("round_idx_extra", 128'(round_idx), 128'(4'hx));
        prev_ri = round_idx;
      end
      if (done2 && lat2 < 0) lat2 = cnt;
      if (done4 && lat4 < 0) lat4 = cnt;
      if (done) begin
        lat1 = cnt;
        break;
      end
      if (mode == 3 && cnt >= 5 && cnt < 20) begin
        start      = ~start;
        ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      if (mode == 3 && cnt == 20) start = 1'b0;
    end
    check("done_seen", 128'(done), 128'(1));
    check("busy_low_at_done", 128'(busy), 128'(0));
    check("busy_done_exclusive", 128'(ovl), 128'(0));
    check("plaintext", plaintext, q_pt.pop_front());
    check("round_idx_seq_len", 128'(q_ri.size()), 128'(0));
    q_ri.delete();
    if (mode != 1) repeat (2) @(negedge Clk);
  endtask

  initial begin
    logic [7:0]   inv;
    logic [0:127] ptv, ctv;
    Reset      = 1'b1;
    start      = 1'b0;
    ciphertext = '0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    ks = expand(KEY);
    repeat (2) @(negedge Clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_plaintext", plaintext, 128'(0));
    check("rst_round_idx", 128'(round_idx), 128'(0));
    check("rst_round_idx_c2", 128'(ri2), 128'(0));
    check("rst_round_idx_c4", 128'(ri4), 128'(0));
    Reset = 1'b0;
    @(negedge Clk);

    // FIPS-197 C.1 on all three column schedules
    run_op(CT1, PT1, 0);
    check("latency_cols1", 128'(lat1), 128'(66));
    check("latency_cols2", 128'(lat2), 128'(48));
    check("latency_cols4", 128'(lat4), 128'(39));
    check("plaintext_cols2", pt2_o, PT1);
    check("plaintext_cols4", pt4_o, PT1);

    // start held through completion, then released
    ptv = {$urandom(), $urandom(), $urandom(), $urandom()};
    ctv = encrypt(ptv, ks);
    run_op(ctv, ptv, 1);
    repeat (5) @(negedge Clk);
    check("hold_done", 128'(done), 128'(1));
    check("hold_busy", 128'(busy), 128'(0));
    check("hold_plaintext", plaintext, ptv);
    start = 1'b0;
    @(negedge Clk);
    check("release_done", 128'(done), 128'(0));
    check("release_busy", 128'(busy), 128'(0));
    check("release_plaintext", plaintext, ptv);
    @(negedge Clk);

    // abort by async reset, then rerun
    run_op(CT1, PT1, 2);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    run_op(CT1, PT1, 0);

    // disturbed inputs while busy, then a fresh vector
    ptv = {$urandom(), $urandom(), $urandom(), $urandom()};
    ctv = encrypt(ptv, ks);
    run_op(ctv, ptv, 3);
    ptv = {$urandom(), $urandom(), $urandom(), $urandom()};
    ctv = encrypt(ptv, ks);
    run_op(ctv, ptv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
